// File: rtl/data_mem_unit_if.sv
// Core <-> data-memory request/response bundle (LW/SW strobes, address, store data, stall, load data).
interface data_mem_unit_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [2:0]  funct3;
  logic [31:0] read_data;
  logic        stall;
  logic        misaligned;

  modport master (
    output MemRead, MemWrite, addr, write_data, funct3,
    input  read_data, stall, misaligned
  );

  modport slave (
    input  MemRead, MemWrite, addr, write_data, funct3,
    output read_data, stall, misaligned
  );
endinterface

// File: rtl/data_mem_unit.sv
// Fixed-latency word RAM responder that stalls the core until each access completes.
// Define DMEM_BYTE_EN for funct3-driven byte/half accesses; otherwise every access is a 32-bit word.
module data_mem_unit #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            r_rd, r_wr;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_mis;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req, w_fire, w_illegal, w_bad;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_word, w_merged, w_load;

  assign w_req     = bus.MemRead | bus.MemWrite;
  assign w_fire    = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_illegal = r_rd & r_wr;
  assign w_idx     = r_addr[AW+1:2];
  assign w_word    = r_mem[w_idx];

  assign bus.stall      = w_req & (r_state != DONE) & ~rst;
  assign bus.read_data  = r_rdata;
  assign bus.misaligned = r_mis;

`ifdef DMEM_BYTE_EN
  logic [2:0]  r_f3;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused;

  assign w_unused = &{1'b0, bus.addr[31:AW+2]};
  assign w_byte   = w_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half   = w_word[{r_addr[1], 4'b0000} +: 16];

  // Loads accept LB/LH/LW/LBU/LHU, stores only SB/SH/SW; anything else is rejected.
  always_comb begin
    w_bad = 1'b1;
    case (r_f3)
      3'b000:         w_bad = 1'b0;
      3'b001:         w_bad = r_addr[0];
      3'b010:         w_bad = (r_addr[1:0] != 2'b00);
      3'b100:         w_bad = ~r_rd;
      3'b101:         w_bad = ~r_rd | r_addr[0];
      default:        w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_merged = w_word;
    case (r_f3[1:0])
      2'b00:   w_merged[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
      2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
      default: w_merged = r_wdata;
    endcase
  end

  always_comb begin
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = w_word;
    endcase
  end
`else
  logic w_unused;

  assign w_unused = &{1'b0, bus.addr[31:AW+2], bus.funct3};
  assign w_bad    = (r_addr[1:0] != 2'b00);
  assign w_merged = r_wdata;
  assign w_load   = w_word;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (w_req) begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = 4'(LATENCY - 1);
      end
      WAIT: if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
            else               w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The request is captured at acceptance so a mid-WAIT drop of req still completes the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_mis   <= 1'b0;
`ifdef DMEM_BYTE_EN
      r_f3    <= 3'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mis   <= w_fire & (w_illegal | w_bad);
      if (r_state == IDLE && w_req) begin
        r_rd    <= bus.MemRead;
        r_wr    <= bus.MemWrite;
        r_addr  <= bus.addr[AW+1:0];
        r_wdata <= bus.write_data;
`ifdef DMEM_BYTE_EN
        r_f3    <= bus.funct3;
`endif
      end
      if (w_fire) begin
        if (w_illegal || w_bad) r_rdata <= 32'd0;
        else if (r_rd)          r_rdata <= w_load;
      end
    end
  end

  // Reset forces IDLE, so a store caught mid-WAIT never reaches the array.
  always_ff @(posedge clk) begin
    if (w_fire && r_wr && !r_rd && !w_bad) r_mem[w_idx] <= w_merged;
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: stall timing, load data, misaligned pulses, wrap, reset abort.
module tb_data_mem_unit;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_unit_if bus();

  data_mem_unit #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] exp_last = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the rising edge that ends DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_mis);
    int   n;
    exp_t e;
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.addr       = a;
    bus.write_data = d;
    bus.funct3     = f3;
    sb_q.push_back({exp_rd, exp_mis});
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
    end
    chk("stall_cycles", 32'(n), 32'(LAT + 1));
    e = sb_q.pop_front();
    chk("read_data", bus.read_data, e.rd);
    chk("misaligned", {31'd0, bus.misaligned}, {31'd0, e.mis});
    @(posedge clk); #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    chk("mis_pulse_end", {31'd0, bus.misaligned}, 32'd0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp, input logic mis);
    access(1'b1, 1'b0, a, 32'd0, f3, exp, mis);
    exp_last = exp;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3, input logic mis);
    access(1'b0, 1'b1, a, d, f3, mis ? 32'd0 : exp_last, mis);
    if (mis) exp_last = 32'd0;
  endtask

  logic [31:0] r_a [6];
  logic [31:0] r_d [6];

  initial begin
    bus.MemRead    = 1'b1;
    bus.MemWrite   = 1'b0;
    bus.addr       = 32'd0;
    bus.write_data = 32'd0;
    bus.funct3     = 3'b010;
    #12;
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_rdata", bus.read_data, 32'd0);
    chk("rst_mis", {31'd0, bus.misaligned}, 32'd0);
    @(negedge clk);
    bus.MemRead = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    st(32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
    ld(32'h10, 3'b010, 32'hDEADBEEF, 1'b0);
    ld(32'h12, 3'b010, 32'd0, 1'b1);
    ld(32'h10, 3'b010, 32'hDEADBEEF, 1'b0);
    st(32'h400, 32'h12345678, 3'b010, 1'b0);
    ld(32'h0, 3'b010, 32'h12345678, 1'b0);

    access(1'b1, 1'b1, 32'h10, 32'h0, 3'b010, 32'd0, 1'b1);
    exp_last = 32'd0;
    ld(32'h10, 3'b010, 32'hDEADBEEF, 1'b0);

    st(32'h20, 32'h0BADF00D, 3'b010, 1'b0);
    ld(32'h20, 3'b010, 32'h0BADF00D, 1'b0);

    // Abort a store with reset while it sits in WAIT.
    bus.MemWrite   = 1'b1;
    bus.addr       = 32'h20;
    bus.write_data = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_stall", {31'd0, bus.stall}, 32'd0);
    chk("abort_rdata", bus.read_data, 32'd0);
    @(negedge clk);
    bus.MemWrite = 1'b0;
    rst = 1'b0;
    exp_last = 32'd0;
    @(posedge clk); #1;
    ld(32'h20, 3'b010, 32'h0BADF00D, 1'b0);

    // Request dropped mid-WAIT: the store must still land.
    bus.MemWrite   = 1'b1;
    bus.addr       = 32'h40;
    bus.write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.MemWrite = 1'b0;
    #1;
    chk("drop_stall", {31'd0, bus.stall}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("drop_rdata_hold", bus.read_data, exp_last);
    ld(32'h40, 3'b010, 32'hCAFEF00D, 1'b0);

    for (int i = 0; i < 6; i++) begin
      r_a[i] = {$urandom_range(3, 0) * 32'h400} | ((32'(64 + i * 8) + $urandom_range(7, 0)) << 2);
      r_d[i] = $urandom;
      st(r_a[i], r_d[i], 3'b010, 1'b0);
    end
    for (int i = 5; i >= 0; i--) ld(r_a[i] & 32'h3FC, 3'b010, r_d[i], 1'b0);

`ifdef DMEM_BYTE_EN
    st(32'h30, 32'h11223344, 3'b010, 1'b0);
    st(32'h31, 32'h000000FF, 3'b000, 1'b0);
    ld(32'h30, 3'b010, 32'h1122FF44, 1'b0);
    ld(32'h31, 3'b000, 32'hFFFFFFFF, 1'b0);
    ld(32'h31, 3'b100, 32'h000000FF, 1'b0);
    ld(32'h31, 3'b001, 32'd0, 1'b1);
    ld(32'h32, 3'b101, 32'h00001122, 1'b0);
    ld(32'h30, 3'b110, 32'd0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
